// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register slice with optional two-entry skid
// buffer, synchronous flush and a saturating back-pressure cycle counter.
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             _clk,
    input  logic             _rst,
    input  logic [WIDTH-1:0] _data,
    input  logic             _valid,
    output logic             ready_,
    output logic [WIDTH-1:0] data_,
    output logic             valid_,
    input  logic             _ready,
    input  logic             _flush,
    output logic [1:0]       count_,
    output logic [CNT_W-1:0] stall_cnt_
);

    // Handshake: a beat moves on an edge where valid and ready are both 1;
    // valid never waits on ready, and a raised valid holds its data until taken.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             ready_q;
    logic             in_fire;
    logic             out_fire;

    assign valid_   = (state != EMPTY);
    assign data_    = head;
    assign count_   = state;
    // In skid mode ready_ comes straight from a flop so _ready never reaches it.
    assign ready_   = (SKID != 0) ? ready_q : (!valid_ | _ready);
    assign in_fire  = _valid & ready_;
    assign out_fire = valid_ & _ready;

    always_comb begin
        state_nxt = state;
        if (_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_nxt = ONE;
                ONE: begin
                    if (in_fire && !out_fire && (SKID != 0)) state_nxt = FULL;
                    else if (out_fire && !in_fire)           state_nxt = EMPTY;
                end
                FULL:    if (out_fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge _clk or posedge _rst) begin
        if (_rst) begin
            state      <= EMPTY;
            head       <= '0;
            skid       <= '0;
            ready_q    <= 1'b1;
            stall_cnt_ <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
            // Flush leaves the data registers untouched; only occupancy is killed.
            if (!_flush) begin
                case (state)
                    EMPTY: if (in_fire) head <= _data;
                    ONE: begin
                        if (in_fire && out_fire)  head <= _data;
                        else if (in_fire)         skid <= _data;
                    end
                    FULL:    if (out_fire) head <= skid;
                    default: ;
                endcase
            end
            if (valid_ && !_ready && (stall_cnt_ != {CNT_W{1'b1}}))
                stall_cnt_ <= stall_cnt_ + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised pipeline stage register for the uarchsim core. It generalises the fixed per-stage latches with a configurable payload width and a valid/ready handshake. It supports optional two-entry skid buffering, synchronous flush, and a saturating back-pressure counter. Instances sit between pipeline stages and carry packed stage payloads (rd, rs, pc, imm, control signals) with a valid bit, replacing clock masking with explicit back-pressure.

Parameters:
WIDTH, 32, payload width in bits (>=1).
SKID, 1, 1 = two-entry skid buffer with registered ready_; 0 = single register with combinational ready_.
CNT_W, 16, width of the stall-cycle counter.

Ports:
_clk  input  1  clock, rising edge.
_rst  input  1  reset, asynchronous, active-high.
_data  input  WIDTH  upstream payload.
_valid  input  1  upstream payload valid.
ready_  output  1  stage can accept a beat this cycle.
data_  output  WIDTH  downstream payload (head entry).
valid_  output  1  head entry valid.
_ready  input  1  downstream accepts the head entry this cycle.
_flush  input  1  synchronous kill of all held and incoming beats.
count_  output  2  occupancy: 0..1 when SKID=0, 0..2 when SKID=1.
stall_cnt_  output  CNT_W  cycles with valid_=1 and _ready=0, saturating.

Behaviour:
- Reset (_rst=1, asynchronous): valid_=0, skid valid=0, data_=0, skid data=0, count_=0, stall_cnt_=0. ready_=1 in both modes while in reset.
- in_fire = _valid & ready_. out_fire = valid_ & _ready.
- Latency: a beat accepted at edge N is on data_/valid_ after edge N (1 cycle). Back-pressure never drops or duplicates a beat.
- Beats leave the stage in strict acceptance order.
- SKID=0 mode:
  - ready_ = !valid_ | _ready (combinational).
  - On in_fire, the head register loads _data and valid_=1.
  - On out_fire without in_fire, valid_=0.
- SKID=1 mode, states by occupancy:
  - EMPTY: ready_=1. in_fire loads the head and goes to ONE.
  - ONE: ready_=1.
    - in_fire & out_fire: head loads _data, stays in ONE.
    - in_fire only: _data goes into skid, go to FULL.
    - out_fire only: go to EMPTY.
  - FULL: ready_=0, registered (a function of state only, no combinational path from _ready). On out_fire the skid moves to the head and the state goes to ONE. _valid is ignored.
- Flush: when _flush=1 at an edge, the next state is EMPTY regardless of in_fire or out_fire.
  - The incoming beat in that cycle is dropped. Upstream sees it as accepted if ready_ was 1.
  - Data registers hold their values, but valid_=0.
  - Flush has priority over all other events. stall_cnt_ is not cleared by flush.
- stall_cnt_ increments each edge where valid_=1 and _ready=0, including a cycle where flush is also asserted. It saturates at 2^CNT_W-1 with no wrap.
- count_ tracks the state: EMPTY=0, ONE=1, FULL=2.
- Reset mid-operation: all state clears immediately (asynchronously), and held beats are lost.
- data_ is held stable while valid_=1 and _ready=0 (AXI-style stability rule). Upstream is required to hold _data stable while _valid=1 and ready_=0.

Test Plan:
- SKID=1, stream 0x11,0x22,0x33 with _ready=1 constantly -> data_ shows 0x11,0x22,0x33 on consecutive cycles each 1 cycle after acceptance; ready_ stays 1; count_ stays at 1.
- SKID=1, _ready=0 while sending 0xA0,0xA1,0xA2 -> 0xA0 in head, 0xA1 in skid, ready_=0 and count_=2 after the 2nd edge; 0xA2 held upstream. Raising _ready then delivers 0xA0,0xA1,0xA2 in order; stall_cnt_ equals the number of stalled cycles with valid_=1.
- SKID=1 in FULL, assert _flush for 1 cycle with _valid=1 (data 0xFF) -> next cycle valid_=0, count_=0, ready_=1; 0xFF never appears on the output; stall_cnt_ is unchanged by the flush itself.
- SKID=0, hold _ready=0 with valid_=1 -> ready_=0 the same cycle; pulsing _ready=1 with _valid=1 (0x5) replaces the head with 0x5 in one edge (simultaneous in/out).
- CNT_W=2, _ready=0 for 6 cycles with valid_=1 -> stall_cnt_ goes 1,2,3,3,3,3 (saturates at 3).
- Assert _rst asynchronously mid-cycle while FULL -> valid_=0, count_=0, stall_cnt_=0, data_=0 immediately without a clock edge; normal operation resumes after _rst=0.
